shifter_pipe_rev: RTL and testbench

- Parametrised, pipelined successor to the 8-bit combinational rotator.
- Supports rotate, logical shift and arithmetic shift, left or right, on a WIDTH-bit operand.
- Left shifts use the reverse method: bit-reverse the operand, shift right, then bit-reverse the result.
- One shift level per pipeline stage, with valid/ready handshakes on both sides. Sits between a producer datapath and a consumer that may stall.

---
 rtl/shifter_pipe_rev_if.sv | 55 +++++
 rtl/shifter_pipe_rev.sv | 156 +++++++++++++++
 tb/tb_shifter_pipe_rev.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/shifter_pipe_rev_if.sv
// -----------------------------------------------------------------------------
// shifter_pipe_rev_if
// Handshake bundle between a producer, the pipelined shifter and a consumer.
//
// Parameters:
//   WIDTH      operand width (power of 2, >= 4)
// Signals:
//   in_valid / in_ready       input-side handshake
//   in_a, in_amt, in_lr, in_op operand, amount, direction (1 = right), operation
//   out_valid / out_ready     output-side handshake
//   out_y                     result word
//   out_sticky                OR of shifted-out bits (only with SHIFTER_PIPE_STICKY_EN)
// Modports:
//   master  producer/consumer view (drives inputs, takes results)
//   slave   shifter view
// Optional feature macro: SHIFTER_PIPE_STICKY_EN
// -----------------------------------------------------------------------------
interface shifter_pipe_rev_if #(
    parameter int WIDTH = 8
);
    localparam int AMT_W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [AMT_W-1:0] in_amt;
    logic             in_lr;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
`ifdef SHIFTER_PIPE_STICKY_EN
    logic             out_sticky;

    modport master (
        output in_valid, in_a, in_amt, in_lr, in_op, out_ready,
        input  in_ready, out_valid, out_y, out_sticky
    );

    modport slave (
        input  in_valid, in_a, in_amt, in_lr, in_op, out_ready,
        output in_ready, out_valid, out_y, out_sticky
    );
`else
    modport master (
        output in_valid, in_a, in_amt, in_lr, in_op, out_ready,
        input  in_ready, out_valid, out_y
    );

    modport slave (
        input  in_valid, in_a, in_amt, in_lr, in_op, out_ready,
        output in_ready, out_valid, out_y
    );
`endif
endinterface

// File: rtl/shifter_pipe_rev.sv
// -----------------------------------------------------------------------------
// shifter_pipe_rev
// Pipelined rotator / logical / arithmetic shifter, left or right, on a
// WIDTH-bit operand. Left operations are done by bit-reversing the operand,
// shifting right, and reversing the result back. One power-of-two shift level
// is applied per pipeline stage; both sides use valid/ready handshakes and the
// pipeline holds up to AMT_W words.
//
// Parameters:
//   WIDTH  operand width, power of 2 and >= 4 (AMT_W = $clog2(WIDTH) derived)
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; flushes every stage (control and data)
//   bus    shifter_pipe_rev_if.slave:
//            in_valid/in_ready, in_a, in_amt, in_lr (1 = right), in_op
//            (00 rotate, 01 logical, 10 arithmetic, 11 pass-through),
//            out_valid/out_ready, out_y, out_sticky (optional)
// Optional feature macro: SHIFTER_PIPE_STICKY_EN adds out_sticky, the OR of
// all bits shifted out by logical/arithmetic operations.
// -----------------------------------------------------------------------------
module shifter_pipe_rev #(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               reset,
    shifter_pipe_rev_if.slave bus
);
    localparam int AMT_W = $clog2(WIDTH);
    localparam int LAST  = AMT_W - 1;

    localparam logic [1:0] OP_ROT   = 2'b00;
    localparam logic [1:0] OP_LOG   = 2'b01;
    localparam logic [1:0] OP_ARITH = 2'b10;

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = x[WIDTH-1-i];
        end
        return r;
    endfunction

    // Right shift/rotate by a fixed amount sh (1 <= sh < WIDTH).
    function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0] x,
                                                     input logic [1:0]       op,
                                                     input logic             fill,
                                                     input int               sh);
        logic [WIDTH-1:0] r;
        case (op)
            OP_ROT:          r = (x >> sh) | (x << (WIDTH - sh));
            OP_LOG, OP_ARITH: r = (x >> sh) | ({WIDTH{fill}} << (WIDTH - sh));
            default:         r = x;
        endcase
        return r;
    endfunction

    // OR of the sh low bits, i.e. the bits a right shift by sh discards.
    function automatic logic stage_lost(input logic [WIDTH-1:0] x, input int sh);
        logic [WIDTH-1:0] mask;
        mask = (WIDTH'(1) << sh) - WIDTH'(1);
        return |(x & mask);
    endfunction

    logic [AMT_W-1:0] vld_p;
    logic [AMT_W-1:0] adv;
    logic [WIDTH-1:0] data_p  [AMT_W];
    logic [AMT_W-1:0] amt_p   [AMT_W];
    logic [1:0]       op_p    [AMT_W];
    logic             lr_p    [AMT_W];
    logic             fill_p  [AMT_W];
    logic [WIDTH-1:0] shift_out [AMT_W];
`ifdef SHIFTER_PIPE_STICKY_EN
    logic             sticky_p   [AMT_W];
    logic             sticky_out [AMT_W];
`endif

    // A stage only holds when it and every stage after it are full and the
    // consumer is stalling, so the ready chain collapses to a running AND.
    logic full_chain;
    always_comb begin
        full_chain = 1'b1;
        adv        = '0;
        for (int k = AMT_W - 1; k >= 0; k--) begin
            full_chain = full_chain & vld_p[k];
            adv[k]     = bus.out_ready | ~full_chain;
        end
    end

    // Shift level k acts on the output of register k; the last level feeds
    // the output decode directly.
    for (genvar k = 0; k < AMT_W; k++) begin : g_level
        assign shift_out[k] = amt_p[k][k]
                            ? stage_shift(data_p[k], op_p[k], fill_p[k], 1 << k)
                            : data_p[k];
`ifdef SHIFTER_PIPE_STICKY_EN
        assign sticky_out[k] = sticky_p[k]
                             | (amt_p[k][k]
                                & ((op_p[k] == OP_LOG) || (op_p[k] == OP_ARITH))
                                & stage_lost(data_p[k], 1 << k));
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p <= '0;
            for (int k = 0; k < AMT_W; k++) begin
                data_p[k] <= '0;
                amt_p[k]  <= '0;
                op_p[k]   <= '0;
                lr_p[k]   <= 1'b0;
                fill_p[k] <= 1'b0;
`ifdef SHIFTER_PIPE_STICKY_EN
                sticky_p[k] <= 1'b0;
`endif
            end
        end else begin
            // Stage 0: capture, with left operations mapped into the reversed domain
            if (adv[0]) begin
                vld_p[0]  <= bus.in_valid;
                data_p[0] <= bus.in_lr ? bus.in_a : bit_rev(bus.in_a);
                amt_p[0]  <= bus.in_amt;
                op_p[0]   <= bus.in_op;
                lr_p[0]   <= bus.in_lr;
                fill_p[0] <= (bus.in_op == OP_ARITH) && bus.in_lr && bus.in_a[WIDTH-1];
`ifdef SHIFTER_PIPE_STICKY_EN
                sticky_p[0] <= 1'b0;
`endif
            end
            // Stages 1..AMT_W-1: register the previous shift level
            for (int k = 1; k < AMT_W; k++) begin
                if (adv[k]) begin
                    vld_p[k]  <= vld_p[k-1];
                    data_p[k] <= shift_out[k-1];
                    amt_p[k]  <= amt_p[k-1];
                    op_p[k]   <= op_p[k-1];
                    lr_p[k]   <= lr_p[k-1];
                    fill_p[k] <= fill_p[k-1];
`ifdef SHIFTER_PIPE_STICKY_EN
                    sticky_p[k] <= sticky_out[k-1];
`endif
                end
            end
        end
    end

    // Output decode: undo the reversal for left operations; zero when idle.
    assign bus.in_ready  = adv[0] & ~reset;
    assign bus.out_valid = vld_p[LAST];
    assign bus.out_y     = vld_p[LAST]
                         ? (lr_p[LAST] ? shift_out[LAST] : bit_rev(shift_out[LAST]))
                         : '0;
`ifdef SHIFTER_PIPE_STICKY_EN
    assign bus.out_sticky = vld_p[LAST] & sticky_out[LAST];
`endif

endmodule

// File: tb/tb_shifter_pipe_rev.sv
module tb_shifter_pipe_rev;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    shifter_pipe_rev_if #(.WIDTH(W)) bus ();

    shifter_pipe_rev #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_out = 0;
    bit lat_mode = 1'b0;

    typedef struct {
        logic [7:0] y;
        logic       s;
        int         acc;
        bit         lat;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Behavioural reference: plain integer arithmetic on the original operand.
    function automatic logic [7:0] ref_y(input logic [7:0] a, input int amt, input bit lr, input logic [1:0] op);
        int v;
        int r;
        logic signed [7:0] sa;
        v  = int'(a);
        sa = a;
        case (op)
            2'b00: r = lr ? ((v >> amt) | (v << (8 - amt))) : ((v << amt) | (v >> (8 - amt)));
            2'b01: r = lr ? (v >> amt) : (v << amt);
            2'b10: r = lr ? int'(sa >>> amt) : (v << amt);
            default: r = v;
        endcase
        return 8'(r);
    endfunction

    function automatic logic ref_sticky(input logic [7:0] a, input int amt, input bit lr, input logic [1:0] op);
        int v;
        v = int'(a);
        if (amt == 0 || !(op == 2'b01 || op == 2'b10)) return 1'b0;
        if (lr) return ((v & ((1 << amt) - 1)) != 0);
        return ((v >> (8 - amt)) != 0);
    endfunction

    // Scoreboard: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (reset) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("stale_out", 32'(bus.out_valid), 32'd0);
                end else begin
                    chk("out_y", 32'(bus.out_y), 32'(exp_q[0].y));
`ifdef SHIFTER_PIPE_STICKY_EN
                    chk("out_sticky", 32'(bus.out_sticky), 32'(exp_q[0].s));
`endif
                    if (bus.out_ready) begin
                        if (exp_q[0].lat) chk("latency", 32'(cyc - exp_q[0].acc), 32'd3);
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end else begin
                chk("idle_y", 32'(bus.out_y), 32'd0);
`ifdef SHIFTER_PIPE_STICKY_EN
                chk("idle_sticky", 32'(bus.out_sticky), 32'd0);
`endif
            end
            if (bus.in_valid && bus.in_ready) begin
                e.y   = ref_y(bus.in_a, int'(bus.in_amt), bus.in_lr, bus.in_op);
                e.s   = ref_sticky(bus.in_a, int'(bus.in_amt), bus.in_lr, bus.in_op);
                e.acc = cyc;
                e.lat = lat_mode;
                exp_q.push_back(e);
            end
        end
    end

    task automatic set_word(input logic [7:0] a, input logic [2:0] amt, input logic lr, input logic [1:0] op);
        bus.in_a   = a;
        bus.in_amt = amt;
        bus.in_lr  = lr;
        bus.in_op  = op;
    endtask

    task automatic send(input logic [7:0] a, input logic [2:0] amt, input logic lr, input logic [1:0] op);
        logic got;
        int   guard;
        set_word(a, amt, lr, op);
        bus.in_valid = 1'b1;
        got   = 1'b0;
        guard = 0;
        while (!got && guard < 50) begin
            @(negedge clk);
            got = bus.in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!got) chk("send_timeout", 32'(got), 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int i;
        int guard;
        int out_before;
        logic [7:0] bw [5];

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        set_word(8'h00, 3'd0, 1'b1, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_y", 32'(bus.out_y), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed operations with out_ready held high (latency checked)
        lat_mode = 1'b1;
        send(8'hB3, 3'd1, 1'b1, 2'b00);
        send(8'h6C, 3'd2, 1'b0, 2'b00);
        send(8'h96, 3'd3, 1'b1, 2'b10);
        send(8'h96, 3'd3, 1'b1, 2'b01);
        send(8'h99, 3'd4, 1'b0, 2'b01);
        for (int op = 0; op < 4; op++) begin
            for (int lr = 0; lr < 2; lr++) begin
                send(8'hF0, 3'd0, 1'(lr), 2'(op));
            end
        end
        send(8'hA5, 3'd5, 1'b1, 2'b11);
        send(8'h81, 3'd7, 1'b1, 2'b10);
        send(8'h81, 3'd7, 1'b0, 2'b00);
        send(8'h81, 3'd7, 1'b0, 2'b01);
        drain();
        lat_mode = 1'b0;

        // Backpressure: stall the consumer, offer 5 words
        bw[0] = 8'h12; bw[1] = 8'h34; bw[2] = 8'h56; bw[3] = 8'h78; bw[4] = 8'h9A;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        i = 0;
        for (int c = 0; c < 8; c++) begin
            set_word(bw[i], 3'(i + 1), 1'(i % 2), 2'(i % 3));
            @(negedge clk);
            if (bus.in_ready && i < 4) i++;
            @(posedge clk);
            #1;
        end
        chk("bp_accepted", 32'(i), 32'd3);
        @(negedge clk);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        guard = 0;
        while (i < 5 && guard < 50) begin
            set_word(bw[i], 3'(i + 1), 1'(i % 2), 2'(i % 3));
            @(negedge clk);
            if (bus.in_ready) i++;
            @(posedge clk);
            #1;
            guard++;
        end
        chk("bp_all_accepted", 32'(i), 32'd5);
        bus.in_valid = 1'b0;
        drain();

        // Random back-to-back stream with random consumer stalls
        bus.in_valid = 1'b1;
        i = 0;
        guard = 0;
        set_word(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        while (i < 16 && guard < 500) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.in_ready) begin
                i++;
                @(posedge clk);
                #1;
                set_word(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            end else begin
                @(posedge clk);
                #1;
            end
            guard++;
        end
        chk("rand_accepted", 32'(i), 32'd16);
        bus.in_valid = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            guard++;
        end
        bus.out_ready = 1'b1;
        drain();

        // Reset with words in flight; a word offered during reset is dropped
        bus.out_ready = 1'b0;
        send(8'h11, 3'd1, 1'b1, 2'b01);
        send(8'h22, 3'd2, 1'b0, 2'b00);
        send(8'h33, 3'd3, 1'b1, 2'b10);
        set_word(8'h44, 3'd1, 1'b1, 2'b00);
        bus.in_valid = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        out_before    = n_out;
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        chk("mid_rst_no_emit", 32'(n_out - out_before), 32'd0);
        lat_mode = 1'b1;
        send(8'hC3, 3'd2, 1'b1, 2'b10);
        drain();
        chk("post_rst_emit", 32'(n_out - out_before), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
